fetch_epoch_filter: RTL



---
 rtl/fetch_epoch_filter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_epoch_filter.sv
// rtl/fetch_epoch_filter.sv - epoch-based slot filter with a 2-entry skid FIFO toward the ibuffer
module fetch_epoch_filter #(
    parameter int INSTR_PER_FETCH = 4,
    parameter int ILEN            = 32,
    parameter int PLEN            = 32,
    parameter int FTQ_ID_W        = 3,
    parameter int EPOCH_W         = 3,
    parameter int CNT_W           = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic                                fetch_valid_i,
    output logic                                fetch_ready_o,
    input  logic [INSTR_PER_FETCH*ILEN-1:0]     fetch_instrs_i,
    input  logic [PLEN-1:0]                     fetch_pc_i,
    input  logic [INSTR_PER_FETCH-1:0]          fetch_slot_valid_i,
    input  logic [INSTR_PER_FETCH*PLEN-1:0]     fetch_pred_npc_i,
    input  logic [INSTR_PER_FETCH*FTQ_ID_W-1:0] fetch_ftq_id_i,
    input  logic [INSTR_PER_FETCH*EPOCH_W-1:0]  fetch_epoch_i,
    output logic                                fe_valid_o,
    input  logic                                fe_ready_i,
    output logic [INSTR_PER_FETCH*ILEN-1:0]     fe_instrs_o,
    output logic [PLEN-1:0]                     fe_pc_o,
    output logic [INSTR_PER_FETCH-1:0]          fe_slot_valid_o,
    output logic [INSTR_PER_FETCH*PLEN-1:0]     fe_pred_npc_o,
    output logic [INSTR_PER_FETCH*FTQ_ID_W-1:0] fe_ftq_id_o,
    output logic [INSTR_PER_FETCH*EPOCH_W-1:0]  fe_fetch_epoch_o,
    output logic [EPOCH_W-1:0]                  cur_epoch_o,
    output logic [CNT_W-1:0]                    drop_cnt_o
);
    localparam int IW   = INSTR_PER_FETCH * ILEN;
    localparam int NW   = INSTR_PER_FETCH * PLEN;
    localparam int FW   = INSTR_PER_FETCH * FTQ_ID_W;
    localparam int EW   = INSTR_PER_FETCH * EPOCH_W;
    localparam int PC_W = $clog2(3 * INSTR_PER_FETCH + 1);

    logic [EPOCH_W-1:0]         cur_epoch_q;
    logic [CNT_W-1:0]           drop_cnt_q;
    logic [1:0]                 count_q;
    logic                       wr_ptr_q;
    logic                       rd_ptr_q;
    logic [IW-1:0]              instrs_q     [2];
    logic [PLEN-1:0]            pc_q         [2];
    logic [INSTR_PER_FETCH-1:0] slot_valid_q [2];
    logic [NW-1:0]              pred_npc_q   [2];
    logic [FW-1:0]              ftq_id_q     [2];
    logic [EW-1:0]              epoch_q      [2];

    logic [INSTR_PER_FETCH-1:0] survive;
    logic                       acc;
    logic                       push;
    logic                       pop;
    logic [PC_W-1:0]            inc;
    logic [CNT_W:0]             cnt_sum;

    function automatic logic [PC_W-1:0] popcnt(input logic [INSTR_PER_FETCH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int k = 0; k < INSTR_PER_FETCH; k++) begin
            n = n + PC_W'(v[k]);
        end
        return n;
    endfunction

    // Slots survive only if tagged with the epoch in force before any same-cycle flush.
    always_comb begin
        survive = '0;
        for (int k = 0; k < INSTR_PER_FETCH; k++) begin
            survive[k] = fetch_slot_valid_i[k] &&
                         (fetch_epoch_i[k*EPOCH_W +: EPOCH_W] == cur_epoch_q);
        end
    end

    assign fetch_ready_o = (count_q != 2'd2);
    assign fe_valid_o    = (count_q != 2'd0);
    assign acc           = fetch_valid_i & fetch_ready_o;
    assign push          = acc & (|survive) & ~flush_i;
    assign pop           = fe_valid_o & fe_ready_i & ~flush_i;

    // A flush discards the incoming packet and everything still buffered.
    always_comb begin
        inc = '0;
        if (flush_i) begin
            if (acc) begin
                inc = popcnt(fetch_slot_valid_i);
            end
            if (count_q != 2'd0) begin
                inc = inc + popcnt(slot_valid_q[rd_ptr_q]);
            end
            if (count_q == 2'd2) begin
                inc = inc + popcnt(slot_valid_q[~rd_ptr_q]);
            end
        end else if (acc) begin
            inc = popcnt(fetch_slot_valid_i & ~survive);
        end
    end

    assign cnt_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(inc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_epoch_q <= '0;
            drop_cnt_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
        end else begin
            drop_cnt_q <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
            if (flush_i) begin
                cur_epoch_q <= cur_epoch_q + 1'b1;
                count_q     <= '0;
                wr_ptr_q    <= 1'b0;
                rd_ptr_q    <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instrs_q[wr_ptr_q]     <= fetch_instrs_i;
            pc_q[wr_ptr_q]         <= fetch_pc_i;
            slot_valid_q[wr_ptr_q] <= survive;
            pred_npc_q[wr_ptr_q]   <= fetch_pred_npc_i;
            ftq_id_q[wr_ptr_q]     <= fetch_ftq_id_i;
            epoch_q[wr_ptr_q]      <= fetch_epoch_i;
        end
    end

    assign fe_instrs_o      = instrs_q[rd_ptr_q];
    assign fe_pc_o          = pc_q[rd_ptr_q];
    assign fe_slot_valid_o  = slot_valid_q[rd_ptr_q];
    assign fe_pred_npc_o    = pred_npc_q[rd_ptr_q];
    assign fe_ftq_id_o      = ftq_id_q[rd_ptr_q];
    assign fe_fetch_epoch_o = epoch_q[rd_ptr_q];
    assign cur_epoch_o      = cur_epoch_q;
    assign drop_cnt_o       = drop_cnt_q;
endmodule
